// File: rtl/bconv3x3_accum_if.sv
// rtl/bconv3x3_accum_if.sv - 3x3 window input bus and partial-sum output handshake
interface bconv3x3_accum_if #(
   parameter int ACC_W = 16
);
   logic                    buffer_done;
   logic [5:0]              x11, x12, x13, x21, x22, x23, x31, x32, x33;
   logic                    w11, w12, w13, w21, w22, w23, w31, w32, w33;
   logic signed [ACC_W-1:0] psum_out;
   logic                    psum_valid;
   logic                    psum_ready;
   logic                    ch_busy;
   logic                    ovf_err;

   modport master (
      output buffer_done, x11, x12, x13, x21, x22, x23, x31, x32, x33,
      output w11, w12, w13, w21, w22, w23, w31, w32, w33, psum_ready,
      input  psum_out, psum_valid, ch_busy, ovf_err
   );

   modport slave (
      input  buffer_done, x11, x12, x13, x21, x22, x23, x31, x32, x33,
      input  w11, w12, w13, w21, w22, w23, w31, w32, w33, psum_ready,
      output psum_out, psum_valid, ch_busy, ovf_err
   );
endinterface

// File: rtl/bconv3x3_accum.sv
// rtl/bconv3x3_accum.sv - binary-weight 3x3 dot product, channel accumulation, psum handshake
// Optional macro BCONV_RELU_EN clamps negative results to 0 when loaded into psum_out.
module bconv3x3_accum #(
   parameter int TI            = 3,
   parameter int INPUT_CHANNEL = 3,
   parameter int ACC_W         = 16,
   parameter int CNT_W         = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   bconv3x3_accum_if.slave  bus
);
   localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;
   localparam logic [CNT_W-1:0]      LAST_CH = CNT_W'(INPUT_CHANNEL - 1);

   generate
      if (INPUT_CHANNEL < 1 || (INPUT_CHANNEL % TI) != 0 || ACC_W < 12) begin : g_bad_cfg
         $error("bconv3x3_accum: illegal parameter combination");
      end
   endgenerate

   logic [5:0]              x_in [9];
   logic [8:0]              w_in;
   logic signed [6:0]       p_q [9];
   logic signed [6:0]       p_d [9];
   logic                    v1_q, v1_d, v2_q, v2_d;
   logic signed [10:0]      s_q, s_d;
   logic signed [ACC_W:0]   wide_sum;
   logic signed [ACC_W-1:0] acc_q, acc_d, acc_next, load_val;
   logic signed [ACC_W-1:0] psum_out_q, psum_out_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    psum_valid_q, psum_valid_d;
   logic                    ch_busy_q, ch_busy_d;
   logic                    ovf_q, ovf_d;
   logic                    done_pix;

   assign x_in[0] = bus.x11;
   assign x_in[1] = bus.x12;
   assign x_in[2] = bus.x13;
   assign x_in[3] = bus.x21;
   assign x_in[4] = bus.x22;
   assign x_in[5] = bus.x23;
   assign x_in[6] = bus.x31;
   assign x_in[7] = bus.x32;
   assign x_in[8] = bus.x33;
   assign w_in    = {bus.w33, bus.w32, bus.w31, bus.w23, bus.w22, bus.w21,
                     bus.w13, bus.w12, bus.w11};

   // S1: signed product terms; terms hold through bubbles.
   always_comb begin
      v1_d = bus.buffer_done;
      for (int i = 0; i < 9; i++) begin
         p_d[i] = p_q[i];
         if (bus.buffer_done) begin
            p_d[i] = w_in[i] ? $signed({1'b0, x_in[i]}) : -$signed({1'b0, x_in[i]});
         end
      end
   end

   always_comb begin
      v2_d = v1_q;
      s_d  = '0;
      for (int i = 0; i < 9; i++) begin
         s_d = s_d + {{4{p_q[i][6]}}, p_q[i]};
      end
   end

   // S3: symmetric saturating accumulate; the last channel hands the sum off and clears.
   always_comb begin
      wide_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-10){s_q[10]}}, s_q};
      if (wide_sum > SAT_MAX) begin
         acc_next = SAT_MAX[ACC_W-1:0];
      end else if (wide_sum < SAT_MIN) begin
         acc_next = SAT_MIN[ACC_W-1:0];
      end else begin
         acc_next = wide_sum[ACC_W-1:0];
      end
      done_pix = v2_q && (cnt_q == LAST_CH);
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (v2_q) begin
         if (done_pix) begin
            acc_d = '0;
            cnt_d = '0;
         end else begin
            acc_d = acc_next;
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
      ch_busy_d = (cnt_d != '0);
   end

   always_comb begin
`ifdef BCONV_RELU_EN
      load_val = acc_next[ACC_W-1] ? '0 : acc_next;
`else
      load_val = acc_next;
`endif
      psum_out_d   = psum_out_q;
      psum_valid_d = psum_valid_q;
      ovf_d        = ovf_q;
      if (psum_valid_q && bus.psum_ready) begin
         psum_valid_d = 1'b0;
      end
      if (done_pix) begin
         if (!psum_valid_q || bus.psum_ready) begin
            psum_out_d   = load_val;
            psum_valid_d = 1'b1;
         end else begin
            ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) p_q[i] <= '0;
         v1_q         <= 1'b0;
         v2_q         <= 1'b0;
         s_q          <= '0;
         acc_q        <= '0;
         cnt_q        <= '0;
         psum_out_q   <= '0;
         psum_valid_q <= 1'b0;
         ch_busy_q    <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         for (int i = 0; i < 9; i++) p_q[i] <= p_d[i];
         v1_q         <= v1_d;
         v2_q         <= v2_d;
         s_q          <= s_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         psum_out_q   <= psum_out_d;
         psum_valid_q <= psum_valid_d;
         ch_busy_q    <= ch_busy_d;
         ovf_q        <= ovf_d;
      end
   end

   assign bus.psum_out   = psum_out_q;
   assign bus.psum_valid = psum_valid_q;
   assign bus.ch_busy    = ch_busy_q;
   assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_bconv3x3_accum.sv
// tb/tb_bconv3x3_accum.sv - directed vector bench for bconv3x3_accum
module tb_bconv3x3_accum;
   logic clk = 1'b0;
   logic rst_n;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   bconv3x3_accum_if #(.ACC_W(16)) bus ();

   bconv3x3_accum #(
      .TI(3), .INPUT_CHANNEL(3), .ACC_W(16), .CNT_W(11)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic [53:0] x;
      logic [8:0]  w;
      int          expv;
   } vec_t;

   vec_t vecs[4];

   function automatic int relu(input int v);
`ifdef BCONV_RELU_EN
      return (v < 0) ? 0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string nm, input int act, input int exp_v);
      n_total++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
   endtask

   task automatic drive(input logic [53:0] xv, input logic [8:0] wv, input logic bd);
      bus.buffer_done = bd;
      bus.x11 = xv[5:0];   bus.x12 = xv[11:6];  bus.x13 = xv[17:12];
      bus.x21 = xv[23:18]; bus.x22 = xv[29:24]; bus.x23 = xv[35:30];
      bus.x31 = xv[41:36]; bus.x32 = xv[47:42]; bus.x33 = xv[53:48];
      bus.w11 = wv[0]; bus.w12 = wv[1]; bus.w13 = wv[2];
      bus.w21 = wv[3]; bus.w22 = wv[4]; bus.w23 = wv[5];
      bus.w31 = wv[6]; bus.w32 = wv[7]; bus.w33 = wv[8];
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive('0, '0, 1'b0);
   endtask

   task automatic wait_valid(output int cyc);
      bus.buffer_done = 1'b0;
      cyc = 0;
      while (!bus.psum_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      int          cyc;
      int          extra;
      logic [53:0] ones_x;
      logic [53:0] twos_x;
      logic [53:0] fives_x;

      ones_x  = {9{6'd1}};
      twos_x  = {9{6'd2}};
      fives_x = {9{6'd5}};
      vecs[0] = '{"all_ones",  ones_x,       9'h1FF, 27};
      vecs[1] = '{"all_63_neg", {9{6'd63}},  9'h000, relu(-1701)};
      vecs[2] = '{"checker",   {6'd33, 6'd32, 6'd31, 6'd23, 6'd22, 6'd21, 6'd13, 6'd12, 6'd11},
                  9'b101010101, 66};
      vecs[3] = '{"ramp_mixed", {6'd9, 6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1},
                  9'b000001111, relu(-75)};

      rst_n = 1'b0;
      bus.psum_ready = 1'b1;
      drive('0, '0, 1'b0);
      drive('0, '0, 1'b0);
      check("rst_psum_out",   int'(bus.psum_out), 0);
      check("rst_psum_valid", int'(bus.psum_valid), 0);
      check("rst_ch_busy",    int'(bus.ch_busy), 0);
      check("rst_ovf_err",    int'(bus.ovf_err), 0);
      rst_n = 1'b1;
      idle(2);

      for (int v = 0; v < 4; v++) begin
         for (int k = 0; k < 3; k++) drive(vecs[v].x, vecs[v].w, 1'b1);
         wait_valid(cyc);
         check({vecs[v].name, "_latency"}, cyc, 2);
         check({vecs[v].name, "_psum"}, int'(bus.psum_out), vecs[v].expv);
         check({vecs[v].name, "_busy_clr"}, int'(bus.ch_busy), 0);
         idle(1);
         check({vecs[v].name, "_pulse"}, int'(bus.psum_valid), 0);
         idle(2);
      end

      drive(ones_x, 9'h1FF, 1'b1);
      idle(5);
      check("gap_busy", int'(bus.ch_busy), 1);
      check("gap_no_valid", int'(bus.psum_valid), 0);
      drive(ones_x, 9'h1FF, 1'b1);
      idle(3);
      drive(ones_x, 9'h1FF, 1'b1);
      wait_valid(cyc);
      check("gap_latency", cyc, 2);
      check("gap_psum", int'(bus.psum_out), 27);
      check("gap_busy_clr", int'(bus.ch_busy), 0);
      idle(3);

      bus.psum_ready = 1'b0;
      for (int k = 0; k < 3; k++) drive(ones_x, 9'h1FF, 1'b1);
      wait_valid(cyc);
      check("bp_first", int'(bus.psum_out), 27);
      for (int k = 0; k < 3; k++) drive(twos_x, 9'h1FF, 1'b1);
      idle(5);
      check("bp_keep_old", int'(bus.psum_out), 27);
      check("bp_valid_held", int'(bus.psum_valid), 1);
      check("bp_ovf_set", int'(bus.ovf_err), 1);
      bus.psum_ready = 1'b1;
      idle(1);
      check("bp_valid_drop", int'(bus.psum_valid), 0);
      check("bp_ovf_sticky", int'(bus.ovf_err), 1);

      drive(fives_x, 9'h1FF, 1'b1);
      drive(fives_x, 9'h1FF, 1'b1);
      idle(3);
      check("mid_busy", int'(bus.ch_busy), 1);
      rst_n = 1'b0;
      #2;
      check("mid_rst_busy", int'(bus.ch_busy), 0);
      check("mid_rst_ovf", int'(bus.ovf_err), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);
      for (int k = 0; k < 3; k++) drive(ones_x, 9'h1FF, 1'b1);
      wait_valid(cyc);
      check("post_rst_latency", cyc, 2);
      check("post_rst_psum", int'(bus.psum_out), 27);
      extra = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         if (bus.psum_valid) extra++;
      end
      check("post_rst_single", extra, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
